// File: rtl/alu_defs_pkg.sv
// Shared function codes and issue-FSM state encoding for the ALU issue controller,
// TotalALU and their benches.
package alu_defs_pkg;

   localparam logic [5:0] FN_SLL  = 6'd0;
   localparam logic [5:0] FN_MFHI = 6'd16;
   localparam logic [5:0] FN_MFLO = 6'd18;
   localparam logic [5:0] FN_DIVU = 6'd27;
   localparam logic [5:0] FN_ADD  = 6'd32;
   localparam logic [5:0] FN_SUB  = 6'd34;
   localparam logic [5:0] FN_AND  = 6'd36;
   localparam logic [5:0] FN_OR   = 6'd37;
   localparam logic [5:0] FN_SLT  = 6'd42;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   // Codes that complete in a single ALU cycle (DIVU is handled separately).
   function automatic logic is_single_cycle(input logic [5:0] funct);
      case (funct)
         FN_SLL, FN_MFHI, FN_MFLO, FN_ADD, FN_SUB,
         FN_AND, FN_OR, FN_SLT: is_single_cycle = 1'b1;
         default:               is_single_cycle = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/issue_cycle_counter.sv
// Loadable down-counter that times how long DIVU is held on the ALU Signal port.
// Saturates at zero; zero is flagged combinationally.
module issue_cycle_counter #(
   parameter int CW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          zero
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one operation at a time to an external ALU, waits out DIVU, and returns
// single-cycle results through a valid/ready output port.
module alu_issue_ctrl
   import alu_defs_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int W          = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [5:0]   in_funct,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic [5:0]   alu_signal,
   output logic [W-1:0] alu_dataA,
   output logic [W-1:0] alu_dataB,
   input  logic [W-1:0] alu_out,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_data,
   output logic         res_err,
   output logic [1:0]   dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both
   // high; valid is never withdrawn by this block until the transfer completes.

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

   logic [1:0]    state;
   logic [5:0]    op_funct;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W-1:0]  res_data_q;
   logic          res_err_q;
   logic          cnt_load;
   logic          cnt_dec;
   logic          cnt_zero;
   logic [CW-1:0] cnt_value;

   assign in_ready   = (state == ST_IDLE);
   assign res_valid  = (state == ST_RESP);
   assign res_data   = res_data_q;
   assign res_err    = res_err_q;
   assign dbg_state  = state;
   assign alu_signal = op_funct;
   assign alu_dataA  = op_a;
   assign alu_dataB  = op_b;

   assign cnt_load = in_ready && in_valid && (in_funct == FN_DIVU);
   assign cnt_dec  = (state == ST_DIV);

   issue_cycle_counter #(.CW(CW)) u_div_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (CW'(DIV_CYCLES - 1)),
      .dec      (cnt_dec),
      .count    (cnt_value),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         op_funct   <= FN_AND;
         op_a       <= '0;
         op_b       <= '0;
         res_data_q <= '0;
         res_err_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  if (in_funct == FN_DIVU || is_single_cycle(in_funct)) begin
                     op_funct <= in_funct;
                     op_a     <= in_a;
                     op_b     <= in_b;
                     state    <= (in_funct == FN_DIVU) ? ST_DIV : ST_EXEC;
                  end else begin
                     // Unknown code never reaches the ALU port; report it directly.
                     res_data_q <= '0;
                     res_err_q  <= 1'b1;
                     state      <= ST_RESP;
                  end
               end
            end
            ST_EXEC: begin
               res_data_q <= alu_out;
               res_err_q  <= 1'b0;
               state      <= ST_RESP;
            end
            ST_DIV: begin
               if (cnt_zero) state <= ST_IDLE;
            end
            ST_RESP: begin
               if (res_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   logic unused_cnt;
   assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU (including Hi/Lo) on the
// ALU-side ports.
module tb_alu_issue_ctrl;
   import alu_defs_pkg::*;

   localparam int W = 32;
   localparam int DIV_CYCLES = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [5:0]   in_funct = 6'd0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [5:0]   alu_signal;
   logic [W-1:0] alu_dataA;
   logic [W-1:0] alu_dataB;
   logic [W-1:0] alu_out;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [W-1:0] res_data;
   logic         res_err;
   logic [1:0]   dbg_state;

   int n_checks = 0;
   int n_fail = 0;

   logic [W-1:0] alu_hi = '0;
   logic [W-1:0] alu_lo = '0;

   alu_issue_ctrl #(.DIV_CYCLES(DIV_CYCLES), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_funct   (in_funct),
      .in_a       (in_a),
      .in_b       (in_b),
      .alu_signal (alu_signal),
      .alu_dataA  (alu_dataA),
      .alu_dataB  (alu_dataB),
      .alu_out    (alu_out),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_err    (res_err),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: divider updates Hi/Lo while DIVU is on the Signal port.
   always @(posedge clk) begin
      if (alu_signal == FN_DIVU && alu_dataB != '0) begin
         alu_lo <= alu_dataA / alu_dataB;
         alu_hi <= alu_dataA % alu_dataB;
      end
   end

   always_comb begin
      alu_out = '0;
      case (alu_signal)
         FN_AND:  alu_out = alu_dataA & alu_dataB;
         FN_OR:   alu_out = alu_dataA | alu_dataB;
         FN_ADD:  alu_out = alu_dataA + alu_dataB;
         FN_SUB:  alu_out = alu_dataA - alu_dataB;
         FN_SLT:  alu_out = ($signed(alu_dataA) < $signed(alu_dataB)) ? 1 : 0;
         FN_SLL:  alu_out = alu_dataA << alu_dataB[4:0];
         FN_MFHI: alu_out = alu_hi;
         FN_MFLO: alu_out = alu_lo;
         default: alu_out = '0;
      endcase
   end

   // Called just after a falling edge; returns just after the falling edge that
   // follows the accepting rising edge. waits = falling edges spent with in_ready low.
   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int waits);
      in_valid = 1'b1;
      in_funct = f;
      in_a = a;
      in_b = b;
      waits = 0;
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL issue_timeout: in_ready still %0b after %0d cycles, required 1", in_ready, waits);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %0b, required 0", res_valid); end
      n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_err: got %0b, required 0", res_err); end
      n_checks++; if (res_data !== 32'd0) begin n_fail++; $display("FAIL reset_res_data: got %0h, required 0", res_data); end
      n_checks++; if (alu_signal !== 6'd36) begin n_fail++; $display("FAIL reset_alu_signal: got %0d, required 36", alu_signal); end
      n_checks++; if (alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin n_fail++; $display("FAIL reset_alu_data: got %0h/%0h, required 0/0", alu_dataA, alu_dataB); end
      n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE); end
      reset = 1'b1;
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
   endtask

   task automatic test_add();
      int w;
      res_ready = 1'b1;
      issue(FN_ADD, 32'd5, 32'd7, w);
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL add_busy: in_ready got %0b, required 0", in_ready); end
      n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid: got %0b, required 0", res_valid); end
      n_checks++; if (alu_signal !== 6'd32 || alu_dataA !== 32'd5 || alu_dataB !== 32'd7) begin n_fail++; $display("FAIL add_alu_port: got %0d %0h %0h, required 32 5 7", alu_signal, alu_dataA, alu_dataB); end
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %0b, required 1", res_valid); end
      n_checks++; if (res_data !== 32'd12) begin n_fail++; $display("FAIL add_data: got %0d, required 12", res_data); end
      n_checks++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %0b, required 0", res_err); end
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL add_handoff: valid/ready got %0b/%0b, required 0/1", res_valid, in_ready); end
   endtask

   task automatic test_divu_mflo_mfhi();
      int w;
      int busy;
      logic saw_valid;
      issue(FN_DIVU, 32'd100, 32'd7, w);
      busy = 0;
      saw_valid = 1'b0;
      while (!in_ready && busy < 100) begin
         if (res_valid) saw_valid = 1'b1;
         n_checks++; if (alu_signal !== 6'd27 || alu_dataA !== 32'd100) begin n_fail++; $display("FAIL divu_port_hold: got %0d %0d, required 27 100", alu_signal, alu_dataA); end
         @(negedge clk);
         busy++;
      end
      n_checks++; if (busy !== 32) begin n_fail++; $display("FAIL divu_busy_cycles: got %0d, required 32", busy); end
      n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL divu_no_result: res_valid got %0b, required 0", saw_valid); end
      n_checks++; if (alu_signal !== 6'd27) begin n_fail++; $display("FAIL divu_signal_kept: got %0d, required 27", alu_signal); end
      issue(FN_MFLO, 32'd0, 32'd0, w);
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd14) begin n_fail++; $display("FAIL mflo_data: valid %0b data %0d, required 1 14", res_valid, res_data); end
      @(negedge clk);
      issue(FN_MFHI, 32'd0, 32'd0, w);
      n_checks++; if (w !== 0) begin n_fail++; $display("FAIL mfhi_accept_wait: got %0d, required 0", w); end
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd2) begin n_fail++; $display("FAIL mfhi_data: valid %0b data %0d, required 1 2", res_valid, res_data); end
      @(negedge clk);
   endtask

   task automatic test_unknown();
      int w;
      issue(6'd63, 32'd9, 32'd9, w);
      n_checks++; if (res_valid !== 1'b1 || res_err !== 1'b1) begin n_fail++; $display("FAIL unk_valid_err: got %0b/%0b, required 1/1", res_valid, res_err); end
      n_checks++; if (res_data !== 32'd0) begin n_fail++; $display("FAIL unk_data: got %0h, required 0", res_data); end
      n_checks++; if (alu_signal !== 6'd16 || alu_dataA !== 32'd0) begin n_fail++; $display("FAIL unk_alu_port: got %0d %0h, required 16 0", alu_signal, alu_dataA); end
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL unk_handoff: ready/valid got %0b/%0b, required 1/0", in_ready, res_valid); end
   endtask

   task automatic test_sub_backpressure();
      int w;
      res_ready = 1'b0;
      issue(FN_SUB, 32'd3, 32'd10, w);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (res_valid !== 1'b1 || res_data !== 32'hFFFF_FFF9 || res_err !== 1'b0) begin n_fail++; $display("FAIL sub_hold[%0d]: valid %0b data %0h err %0b, required 1 fffffff9 0", i, res_valid, res_data, res_err); end
         n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sub_hold_ready[%0d]: got %0b, required 0", i, in_ready); end
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL sub_release: valid/ready got %0b/%0b, required 0/1", res_valid, in_ready); end
   endtask

   task automatic test_reset_in_div();
      int w;
      issue(FN_DIVU, 32'd50, 32'd3, w);
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++; if (res_valid !== 1'b0 || res_err !== 1'b0 || res_data !== 32'd0) begin n_fail++; $display("FAIL rstdiv_result: %0b %0b %0h, required 0 0 0", res_valid, res_err, res_data); end
      n_checks++; if (alu_signal !== 6'd36 || alu_dataA !== 32'd0 || alu_dataB !== 32'd0) begin n_fail++; $display("FAIL rstdiv_alu_port: %0d %0h %0h, required 36 0 0", alu_signal, alu_dataA, alu_dataB); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstdiv_ready: got %0b, required 1", in_ready); end
      @(negedge clk);
      reset = 1'b1;
      issue(FN_ADD, 32'd1, 32'd1, w);
      n_checks++; if (w !== 0) begin n_fail++; $display("FAIL rstdiv_residual_busy: waited %0d, required 0", w); end
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd2) begin n_fail++; $display("FAIL rstdiv_add: valid %0b data %0d, required 1 2", res_valid, res_data); end
      @(negedge clk);
   endtask

   task automatic test_mfhi_during_div();
      int w;
      issue(FN_DIVU, 32'd45, 32'd6, w);
      issue(FN_MFHI, 32'd0, 32'd0, w);
      n_checks++; if (w !== 32) begin n_fail++; $display("FAIL mfhi_wait: got %0d, required 32", w); end
      @(negedge clk);
      n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd3) begin n_fail++; $display("FAIL mfhi_after_div: valid %0b data %0d, required 1 3", res_valid, res_data); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int w;
      issue(FN_OR, 32'hF0, 32'h0F, w);
      @(negedge clk);
      n_checks++; if (res_data !== 32'hFF) begin n_fail++; $display("FAIL or_data: got %0h, required ff", res_data); end
      @(negedge clk);
      issue(FN_SLT, 32'hFFFF_FFFF, 32'd1, w);
      @(negedge clk);
      n_checks++; if (res_data !== 32'd1) begin n_fail++; $display("FAIL slt_data: got %0h, required 1", res_data); end
      @(negedge clk);
      issue(FN_SLL, 32'd3, 32'd4, w);
      @(negedge clk);
      n_checks++; if (res_data !== 32'd48) begin n_fail++; $display("FAIL sll_data: got %0d, required 48", res_data); end
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_divu_mflo_mfhi();
      test_unknown();
      test_sub_backpressure();
      test_reset_in_div();
      test_mfhi_during_div();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
